// File: rtl/mem_request_sequencer_if.sv
// Request/response handshake bundle for mem_request_sequencer.
// The master side issues requests and consumes responses; the slave side is the sequencer.
interface mem_request_sequencer_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  resp_valid;
    logic [ADDR_WIDTH-1:0] resp_addr;
    logic [DATA_WIDTH-1:0] resp_data;

    modport master (
        output req_valid, req_write, req_addr, req_data,
        input  req_ready, resp_valid, resp_addr, resp_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_data,
        output req_ready, resp_valid, resp_addr, resp_data
    );
endinterface

// File: rtl/mem_request_sequencer.sv
// In-order request FIFO feeding a setup/strobe/hold sequencer for a small
// asynchronous-read memory; read data comes back on a one-cycle response strobe.
module mem_request_sequencer #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    mem_request_sequencer_if.slave      bus,
    output logic [ADDR_WIDTH-1:0]       mem_address,
    output logic [DATA_WIDTH-1:0]       mem_data_in,
    output logic                        mem_write_enable,
    input  logic [DATA_WIDTH-1:0]       mem_data_out,
    output logic                        busy,
    output logic [$clog2(DEPTH):0]      count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_COUNT  = CW'(1'b1);
    localparam logic [PW-1:0] ONE_PTR    = PW'(1'b1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        WRITE   = 3'd2,
        HOLD    = 3'd3,
        CAPTURE = 3'd4
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [DEPTH-1:0]      fifo_write_r;
    logic [ADDR_WIDTH-1:0] fifo_addr_r [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_r [DEPTH];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic                  cur_write_r;
    logic [ADDR_WIDTH-1:0] mem_address_r;
    logic [DATA_WIDTH-1:0] mem_data_in_r;
    logic                  mem_we_r;
    logic                  resp_valid_r;
    logic [ADDR_WIDTH-1:0] resp_addr_r;
    logic [DATA_WIDTH-1:0] resp_data_r;
    logic                  full_s;
    logic                  empty_s;
    logic                  push_s;
    logic                  pop_s;

    // FIFO status and handshake qualification
    always_comb begin
        full_s  = (count_r == FULL_COUNT);
        empty_s = (count_r == {CW{1'b0}});
        push_s  = bus.req_valid && !full_s;
        pop_s   = (state_r == IDLE) && !empty_s;
    end

    // Next-state logic of the access sequencer
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (pop_s) state_s = SETUP;
                else       state_s = IDLE;
            end
            SETUP: begin
                if (cur_write_r) state_s = WRITE;
                else             state_s = CAPTURE;
            end
            WRITE:   state_s = HOLD;
            HOLD:    state_s = IDLE;
            CAPTURE: state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_s;
    end

    // FIFO storage, pointers and separate occupancy counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_write_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr_r[i] <= {ADDR_WIDTH{1'b0}};
                fifo_data_r[i] <= {DATA_WIDTH{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                fifo_write_r[wr_ptr_r] <= bus.req_write;
                fifo_addr_r[wr_ptr_r]  <= bus.req_addr;
                fifo_data_r[wr_ptr_r]  <= bus.req_data;
                wr_ptr_r               <= wr_ptr_r + ONE_PTR;
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + ONE_PTR;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + ONE_COUNT;
                2'b01:   count_r <= count_r - ONE_COUNT;
                default: count_r <= count_r;
            endcase
        end
    end

    // Memory pins and response: address/data only move on the pop edge,
    // write strobe is decoded from the next state so it stays a clean flop output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_write_r   <= 1'b0;
            mem_address_r <= {ADDR_WIDTH{1'b0}};
            mem_data_in_r <= {DATA_WIDTH{1'b0}};
            mem_we_r      <= 1'b0;
            resp_valid_r  <= 1'b0;
            resp_addr_r   <= {ADDR_WIDTH{1'b0}};
            resp_data_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            if (pop_s) begin
                cur_write_r   <= fifo_write_r[rd_ptr_r];
                mem_address_r <= fifo_addr_r[rd_ptr_r];
                mem_data_in_r <= fifo_data_r[rd_ptr_r];
            end
            mem_we_r     <= (state_s == WRITE);
            resp_valid_r <= (state_r == CAPTURE);
            if (state_r == CAPTURE) begin
                resp_addr_r <= mem_address_r;
                resp_data_r <= mem_data_out;
            end
        end
    end

    assign bus.req_ready    = !full_s;
    assign bus.resp_valid   = resp_valid_r;
    assign bus.resp_addr    = resp_addr_r;
    assign bus.resp_data    = resp_data_r;
    assign mem_address      = mem_address_r;
    assign mem_data_in      = mem_data_in_r;
    assign mem_write_enable = mem_we_r;
    assign busy             = (state_r != IDLE) || !empty_s;
    assign count            = count_r;
endmodule

// File: tb/tb_mem_request_sequencer.sv
// Randomised bench for mem_request_sequencer: a 16x4 memory model plus a
// reference that applies requests in acceptance order to predict writes and read data.
module tb_mem_request_sequencer;
    localparam int AW = 4;
    localparam int DW = 4;
    localparam int DEPTH = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;
    logic          mem_write_enable;
    logic          busy;
    logic [CW-1:0] count;

    mem_request_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_request_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_write_enable(mem_write_enable), .mem_data_out(mem_data_out),
        .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem_model [16];
    logic [DW-1:0] ref_mem [16];
    logic [7:0]    exp_wr_q [$];
    logic [7:0]    exp_rsp_q [$];
    int            checks = 0;
    int            fails = 0;
    int            we_cycles = 0;
    int            max_count = 0;
    logic [DW-1:0] last_resp_data;
    logic          stall_seen;
    logic [CW-1:0] stall_count;

    // Memory: combinational read, write on the clock edge while write_enable is high
    assign mem_data_out = mem_model[mem_address];
    initial begin
        for (int i = 0; i < 16; i++) mem_model[i] = 4'($urandom);
        forever begin
            @(posedge clk);
            if (mem_write_enable === 1'b1) mem_model[mem_address] <= mem_data_in;
        end
    end

    // Monitor: every strobe and response must match the next predicted one
    initial begin
        logic       prev_we;
        logic [3:0] prev_addr;
        logic [3:0] prev_data;
        logic [7:0] exp;
        prev_we = 1'b0; prev_addr = 4'd0; prev_data = 4'd0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                prev_we = 1'b0;
            end else begin
                if (int'(count) > max_count) max_count = int'(count);
                if (mem_write_enable === 1'b1) begin
                    we_cycles++;
                    checks++;
                    if (exp_wr_q.size() == 0) begin
                        fails++;
                        $display("FAIL wr_unexpected: addr %0h data %0h, required no write", mem_address, mem_data_in);
                    end else begin
                        exp = exp_wr_q.pop_front();
                        if ({mem_address, mem_data_in} !== exp)
                            begin fails++; $display("FAIL wr_order: addr/data %h, required %h", {mem_address, mem_data_in}, exp); end
                    end
                    checks++;
                    if (prev_we !== 1'b0 || {prev_addr, prev_data} !== {mem_address, mem_data_in})
                        begin fails++; $display("FAIL wr_setup: prev we %0b a/d %h, now %h", prev_we, {prev_addr, prev_data}, {mem_address, mem_data_in}); end
                end else if (prev_we === 1'b1) begin
                    checks++;
                    if ({prev_addr, prev_data} !== {mem_address, mem_data_in})
                        begin fails++; $display("FAIL wr_hold: a/d %h, required %h", {mem_address, mem_data_in}, {prev_addr, prev_data}); end
                end
                if (bus.resp_valid === 1'b1) begin
                    last_resp_data = bus.resp_data;
                    checks++;
                    if (exp_rsp_q.size() == 0) begin
                        fails++;
                        $display("FAIL resp_unexpected: addr %0h data %0h, required no response", bus.resp_addr, bus.resp_data);
                    end else begin
                        exp = exp_rsp_q.pop_front();
                        if ({bus.resp_addr, bus.resp_data} !== exp)
                            begin fails++; $display("FAIL resp_data: addr/data %h, required %h", {bus.resp_addr, bus.resp_data}, exp); end
                    end
                end
                prev_we = mem_write_enable; prev_addr = mem_address; prev_data = mem_data_in;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int t;
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_data = d;
        t = 0;
        while (bus.req_ready !== 1'b1 && t < 200) begin
            if (!stall_seen) stall_count = count;
            stall_seen = 1'b1;
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++; fails++;
            $display("FAIL send_timeout: req_ready=%0b, required 1 within 200 cycles", bus.req_ready);
        end else if (w) begin
            ref_mem[a] = d;
            exp_wr_q.push_back({a, d});
        end else begin
            exp_rsp_q.push_back({a, ref_mem[a]});
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle(output logic ok);
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (busy === 1'b0) begin ok = 1'b1; break; end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 4'd0; bus.req_data = 4'd0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) ref_mem[i] = mem_model[i];
        checks++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_addr, bus.resp_data, mem_address, mem_data_in, mem_write_enable, busy, count}
            !== {1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 3'd0})
            begin fails++; $display("FAIL reset_async: rdy %0b rv %0b ra %0h rd %0h ma %0h md %0h we %0b busy %0b cnt %0d", bus.req_ready, bus.resp_valid, bus.resp_addr, bus.resp_data, mem_address, mem_data_in, mem_write_enable, busy, count); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.req_ready, busy, count, mem_write_enable} !== {1'b1, 1'b0, 3'd0, 1'b0})
            begin fails++; $display("FAIL reset_idle: rdy %0b busy %0b cnt %0d we %0b, required 1 0 0 0", bus.req_ready, busy, count, mem_write_enable); end
    endtask

    task automatic test_timing();
        logic [3:0] a;
        logic [3:0] d;
        logic       ok;
        a = 4'($urandom); d = 4'($urandom);
        send(1'b1, a, d);
        checks++;
        if ({count, mem_write_enable, busy} !== {3'd1, 1'b0, 1'b1})
            begin fails++; $display("FAIL tim_w_accept: cnt %0d we %0b busy %0b, required 1 0 1", count, mem_write_enable, busy); end
        @(negedge clk);
        checks++;
        if ({count, mem_write_enable, mem_address, mem_data_in} !== {3'd0, 1'b0, a, d})
            begin fails++; $display("FAIL tim_w_setup: cnt %0d we %0b a %0h d %0h, required 0 0 %0h %0h", count, mem_write_enable, mem_address, mem_data_in, a, d); end
        @(negedge clk);
        checks++;
        if (mem_write_enable !== 1'b1) begin fails++; $display("FAIL tim_w_strobe: we %0b, required 1", mem_write_enable); end
        @(negedge clk);
        checks++;
        if ({mem_write_enable, busy} !== {1'b0, 1'b1}) begin fails++; $display("FAIL tim_w_hold: we %0b busy %0b, required 0 1", mem_write_enable, busy); end
        @(negedge clk);
        checks++;
        if ({mem_write_enable, busy} !== {1'b0, 1'b0}) begin fails++; $display("FAIL tim_w_done: we %0b busy %0b, required 0 0", mem_write_enable, busy); end
        send(1'b0, a, 4'd0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL tim_r_capture: resp_valid %0b, required 0", bus.resp_valid); end
        @(negedge clk);
        checks++;
        if ({bus.resp_valid, bus.resp_addr, bus.resp_data} !== {1'b1, a, d})
            begin fails++; $display("FAIL tim_r_resp: rv %0b a %0h d %0h, required 1 %0h %0h", bus.resp_valid, bus.resp_addr, bus.resp_data, a, d); end
        @(negedge clk);
        checks++;
        if ({bus.resp_valid, busy} !== {1'b0, 1'b0}) begin fails++; $display("FAIL tim_r_done: rv %0b busy %0b, required 0 0", bus.resp_valid, busy); end
        wait_idle(ok);
    endtask

    task automatic test_write_read();
        int   we0;
        logic ok;
        we0 = we_cycles;
        send(1'b1, 4'd0, 4'b1010);
        send(1'b1, 4'd1, 4'b0101);
        send(1'b0, 4'd0, 4'd0);
        send(1'b0, 4'd1, 4'd0);
        wait_idle(ok);
        checks++;
        if (!ok || exp_wr_q.size() != 0 || exp_rsp_q.size() != 0)
            begin fails++; $display("FAIL wr_rd_drain: idle %0b pending wr %0d rd %0d, required 1 0 0", ok, exp_wr_q.size(), exp_rsp_q.size()); end
        checks++;
        if (we_cycles - we0 != 2) begin fails++; $display("FAIL wr_rd_pulses: %0d strobe cycles, required 2", we_cycles - we0); end
        checks++;
        if (last_resp_data !== 4'b0101) begin fails++; $display("FAIL wr_rd_last: %b, required 0101", last_resp_data); end
    endtask

    task automatic test_fifo_full();
        logic ok;
        stall_seen = 1'b0; stall_count = 3'd0;
        for (int a = 2; a <= 7; a++) send(1'b1, 4'(a), 4'($urandom));
        checks++;
        if ({stall_seen, stall_count} !== {1'b1, 3'd4})
            begin fails++; $display("FAIL full_stall: stalled %0b at count %0d, required 1 at 4", stall_seen, stall_count); end
        wait_idle(ok);
        for (int a = 2; a <= 7; a++) send(1'b0, 4'(a), 4'd0);
        wait_idle(ok);
        checks++;
        if (!ok || exp_wr_q.size() != 0 || exp_rsp_q.size() != 0)
            begin fails++; $display("FAIL full_drain: idle %0b pending wr %0d rd %0d, required 1 0 0", ok, exp_wr_q.size(), exp_rsp_q.size()); end
    endtask

    task automatic test_raw();
        logic ok;
        max_count = 0;
        send(1'b1, 4'd15, 4'b1111);
        send(1'b0, 4'd15, 4'd0);
        wait_idle(ok);
        checks++;
        if (last_resp_data !== 4'b1111 || exp_rsp_q.size() != 0)
            begin fails++; $display("FAIL raw_data: %b pending %0d, required 1111 0", last_resp_data, exp_rsp_q.size()); end
        checks++;
        if (max_count > 2) begin fails++; $display("FAIL raw_count: max %0d, required <= 2", max_count); end
    endtask

    task automatic test_push_pop();
        logic ok;
        send(1'b1, 4'd8, 4'($urandom));
        send(1'b1, 4'd9, 4'($urandom));
        send(1'b1, 4'd10, 4'($urandom));
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({count, busy} !== {3'd2, 1'b1}) begin fails++; $display("FAIL pp_before: cnt %0d busy %0b, required 2 1", count, busy); end
        send(1'b1, 4'd11, 4'($urandom));
        checks++;
        if ({count, mem_address} !== {3'd2, 4'd9}) begin fails++; $display("FAIL pp_after: cnt %0d addr %0h, required 2 9", count, mem_address); end
        wait_idle(ok);
        for (int a = 8; a <= 11; a++) send(1'b0, 4'(a), 4'd0);
        wait_idle(ok);
        checks++;
        if (!ok || exp_wr_q.size() != 0 || exp_rsp_q.size() != 0)
            begin fails++; $display("FAIL pp_drain: idle %0b pending wr %0d rd %0d, required 1 0 0", ok, exp_wr_q.size(), exp_rsp_q.size()); end
    endtask

    task automatic test_random();
        logic ok;
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(1'($urandom), 4'($urandom), 4'($urandom));
        end
        wait_idle(ok);
        checks++;
        if (!ok || exp_wr_q.size() != 0 || exp_rsp_q.size() != 0)
            begin fails++; $display("FAIL rand_drain: idle %0b pending wr %0d rd %0d, required 1 0 0", ok, exp_wr_q.size(), exp_rsp_q.size()); end
    endtask

    task automatic test_reset_mid_write();
        logic [DW-1:0] snap [16];
        logic [AW-1:0] addrs [5];
        logic [DW-1:0] w1_data;
        logic          ok;
        int            t;
        addrs[0] = 4'd12; addrs[1] = 4'd13; addrs[2] = 4'd14; addrs[3] = 4'd2; addrs[4] = 4'd3;
        for (int i = 0; i < 16; i++) snap[i] = ref_mem[i];
        w1_data = 4'($urandom);
        send(1'b1, addrs[0], w1_data);
        for (int i = 1; i < 5; i++) send(1'b1, addrs[i], ~snap[addrs[i]]);
        t = 0;
        while (mem_write_enable !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        checks++;
        if ({mem_write_enable, count, mem_address} !== {1'b1, 3'd3, 4'd13})
            begin fails++; $display("FAIL rmw_pre: we %0b cnt %0d addr %0h, required 1 3 d", mem_write_enable, count, mem_address); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({mem_write_enable, count, busy, bus.req_ready, bus.resp_valid, mem_address, mem_data_in, bus.resp_addr, bus.resp_data}
            !== {1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0})
            begin fails++; $display("FAIL rmw_reset: we %0b cnt %0d busy %0b rdy %0b rv %0b ma %0h md %0h ra %0h rd %0h", mem_write_enable, count, busy, bus.req_ready, bus.resp_valid, mem_address, mem_data_in, bus.resp_addr, bus.resp_data); end
        exp_wr_q.delete();
        exp_rsp_q.delete();
        for (int i = 0; i < 16; i++) ref_mem[i] = snap[i];
        ref_mem[addrs[0]] = w1_data;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.resp_valid, mem_write_enable, count} !== {1'b0, 1'b0, 3'd0})
                begin fails++; $display("FAIL rmw_quiet: rv %0b we %0b cnt %0d, required 0 0 0", bus.resp_valid, mem_write_enable, count); end
        end
        send(1'b0, 4'd6, 4'd0);
        send(1'b0, 4'd13, 4'd0);
        send(1'b0, 4'd12, 4'd0);
        wait_idle(ok);
        checks++;
        if (!ok || exp_wr_q.size() != 0 || exp_rsp_q.size() != 0)
            begin fails++; $display("FAIL rmw_drain: idle %0b pending wr %0d rd %0d, required 1 0 0", ok, exp_wr_q.size(), exp_rsp_q.size()); end
    endtask

    initial begin
        stall_seen = 1'b0;
        stall_count = 3'd0;
        last_resp_data = 4'd0;
        test_reset();
        test_timing();
        test_write_read();
        test_fifo_full();
        test_raw();
        test_push_pop();
        test_random();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
